// File: rtl/wb_stage_pkg.sv
// -----------------------------------------------------------------------------
// wb_stage_pkg
// Shared pipeline definitions used by control and by the write-back stage:
//   - load type encodings (LW/LB/LBU/LH/LHU; unused codes behave as LW)
//   - register-zero index (writes to it are suppressed)
//   - MEM/WB pipeline entry layout
// -----------------------------------------------------------------------------
package wb_stage_pkg;

    typedef enum logic [2:0] {
        LT_LW  = 3'b000,
        LT_LB  = 3'b001,
        LT_LBU = 3'b010,
        LT_LH  = 3'b011,
        LT_LHU = 3'b100
    } load_type_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic        valid;
        logic        regWrite;
        logic        memToReg;
        logic [2:0]  loadType;
        logic [4:0]  writeReg;
        logic [31:0] aluResult;
        logic [31:0] memData;
    } wb_entry_t;

endpackage

// File: rtl/wb_stage_load_extend.sv
// -----------------------------------------------------------------------------
// load_extend
// Combinational byte/halfword selection and sign/zero extension of load data,
// plus alignment checking for the selected access size.
// Ports:
//   loadType   [2:0]  load type code (see wb_stage_pkg)
//   addr       [1:0]  low address bits (aluResult[1:0])
//   memData    [31:0] raw word returned by memory
//   data       [31:0] extended load result
//   misaligned        access is not naturally aligned (LW, LH, LHU only)
// -----------------------------------------------------------------------------
module load_extend
    import wb_stage_pkg::*;
(
    input  logic [2:0]  loadType,
    input  logic [1:0]  addr,
    input  logic [31:0] memData,
    output logic [31:0] data,
    output logic        misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte     = memData[{addr, 3'b000} +: 8];
        w_half     = addr[1] ? memData[31:16] : memData[15:0];
        data       = memData;
        misaligned = (addr != 2'b00);
        case (loadType)
            LT_LB: begin
                data       = {{24{w_byte[7]}}, w_byte};
                misaligned = 1'b0;
            end
            LT_LBU: begin
                data       = {24'd0, w_byte};
                misaligned = 1'b0;
            end
            LT_LH: begin
                data       = {{16{w_half[15]}}, w_half};
                misaligned = addr[0];
            end
            LT_LHU: begin
                data       = {16'd0, w_half};
                misaligned = addr[0];
            end
            LT_LW: begin
                data       = memData;
                misaligned = (addr != 2'b00);
            end
            default: begin
                // Reserved codes fall back to a full-word load.
                data       = memData;
                misaligned = (addr != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage
// MEM/WB pipeline register and write-back logic.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   stall, flush             hold / kill the MEM/WB entry (flush wins)
//   in_*                     fields from the MEM stage
//   regWrite/writeReg/       register-file write port (file writes on negedge)
//   writeData
//   fwd_valid/fwd_reg/       forwarding to decode/execute
//   fwd_data
//   misalign                 sticky load-alignment error
//   commit_count             number of committed register writes (wraps)
// -----------------------------------------------------------------------------
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic               in_regWrite,
    input  logic               in_memToReg,
    input  logic [2:0]         in_loadType,
    input  logic [4:0]         in_writeReg,
    input  logic [31:0]        in_aluResult,
    input  logic [31:0]        in_memData,
    output logic               regWrite,
    output logic [4:0]         writeReg,
    output logic [31:0]        writeData,
    output logic               fwd_valid,
    output logic [4:0]         fwd_reg,
    output logic [31:0]        fwd_data,
    output logic               misalign,
    output logic [COUNT_W-1:0] commit_count
);

    wb_entry_t          r_entry;
    logic               r_written;
    logic               r_misalign;
    logic [COUNT_W-1:0] r_count;

    logic [31:0]        w_ext_data;
    logic               w_ext_misaligned;
    logic               w_misaligned;
    logic               w_can_write;
    logic               w_regWrite;

    load_extend u_load_extend (
        .loadType   (r_entry.loadType),
        .addr       (r_entry.aluResult[1:0]),
        .memData    (r_entry.memData),
        .data       (w_ext_data),
        .misaligned (w_ext_misaligned)
    );

    always_comb begin
        // Alignment only matters when the result actually comes from memory.
        w_misaligned = w_ext_misaligned & r_entry.memToReg;
        w_can_write  = r_entry.valid & r_entry.regWrite
                     & (r_entry.writeReg != REG_ZERO) & ~w_misaligned;
        // The written flag gates only the port, not forwarding, so a stalled
        // entry keeps forwarding while writing the file exactly once.
        w_regWrite   = w_can_write & ~r_written;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_entry    <= '0;
            r_written  <= 1'b0;
            r_misalign <= 1'b0;
            r_count    <= '0;
        end else begin
            if (flush) begin
                r_entry.valid <= 1'b0;
                r_written     <= 1'b0;
            end else if (!stall) begin
                r_entry.valid     <= in_valid;
                r_entry.regWrite  <= in_regWrite;
                r_entry.memToReg  <= in_memToReg;
                r_entry.loadType  <= in_loadType;
                r_entry.writeReg  <= in_writeReg;
                r_entry.aluResult <= in_aluResult;
                r_entry.memData   <= in_memData;
                r_written         <= 1'b0;
            end else if (w_regWrite) begin
                r_written <= 1'b1;
            end

            if (r_entry.valid && w_misaligned) begin
                r_misalign <= 1'b1;
            end

            if (w_regWrite) begin
                r_count <= r_count + COUNT_W'(1);
            end
        end
    end

    always_comb begin
        regWrite     = w_regWrite;
        writeReg     = r_entry.writeReg;
        writeData    = r_entry.memToReg ? w_ext_data : r_entry.aluResult;
        fwd_valid    = w_can_write;
        fwd_reg      = r_entry.writeReg;
        fwd_data     = writeData;
        misalign     = r_misalign;
        commit_count = r_count;
    end

endmodule

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage
// Directed self-checking bench for wb_stage.
// -----------------------------------------------------------------------------
module tb_wb_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic        in_regWrite;
    logic        in_memToReg;
    logic [2:0]  in_loadType;
    logic [4:0]  in_writeReg;
    logic [31:0] in_aluResult;
    logic [31:0] in_memData;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic        fwd_valid;
    logic [4:0]  fwd_reg;
    logic [31:0] fwd_data;
    logic        misalign;
    logic [31:0] commit_count;

    int tests_run;
    int tests_failed;

    wb_stage #(.COUNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_regWrite  (in_regWrite),
        .in_memToReg  (in_memToReg),
        .in_loadType  (in_loadType),
        .in_writeReg  (in_writeReg),
        .in_aluResult (in_aluResult),
        .in_memData   (in_memData),
        .regWrite     (regWrite),
        .writeReg     (writeReg),
        .writeData    (writeData),
        .fwd_valid    (fwd_valid),
        .fwd_reg      (fwd_reg),
        .fwd_data     (fwd_data),
        .misalign     (misalign),
        .commit_count (commit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r, input logic [2:0] lt,
                         input logic [4:0] wr, input logic [31:0] alu, input logic [31:0] md);
        in_valid     = v;
        in_regWrite  = rw;
        in_memToReg  = m2r;
        in_loadType  = lt;
        in_writeReg  = wr;
        in_aluResult = alu;
        in_memData   = md;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst   = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 32'h0, 32'h0);

        // Reset state
        tick();
        tick();
        check("rst_regWrite",  {31'd0, regWrite}, 32'd0);
        check("rst_writeReg",  {27'd0, writeReg}, 32'd0);
        check("rst_writeData", writeData, 32'd0);
        check("rst_fwd_valid", {31'd0, fwd_valid}, 32'd0);
        check("rst_misalign",  {31'd0, misalign}, 32'd0);
        check("rst_count",     commit_count, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // ALU write to r5
        drive(1'b1, 1'b1, 1'b0, 3'd0, 5'd5, 32'h0000_0007, 32'h0);
        tick();
        check("alu_regWrite",  {31'd0, regWrite}, 32'd1);
        check("alu_writeReg",  {27'd0, writeReg}, 32'd5);
        check("alu_writeData", writeData, 32'h0000_0007);
        check("alu_fwd_valid", {31'd0, fwd_valid}, 32'd1);
        check("alu_fwd_reg",   {27'd0, fwd_reg}, 32'd5);
        check("alu_fwd_data",  fwd_data, 32'h0000_0007);
        check("alu_count0",    commit_count, 32'd0);

        // Load extension cases, back to back
        drive(1'b1, 1'b1, 1'b1, 3'b001, 5'd6, 32'h0000_0001, 32'h1234_80FF);
        tick();
        check("lb_data",  writeData, 32'hFFFF_FF80);
        check("lb_rw",    {31'd0, regWrite}, 32'd1);
        check("alu_count1", commit_count, 32'd1);

        drive(1'b1, 1'b1, 1'b1, 3'b010, 5'd6, 32'h0000_0001, 32'h1234_80FF);
        tick();
        check("lbu_data", writeData, 32'h0000_0080);
        check("lbu_count", commit_count, 32'd2);

        drive(1'b1, 1'b1, 1'b1, 3'b011, 5'd6, 32'h0000_0002, 32'h1234_80FF);
        tick();
        check("lh_a2_data", writeData, 32'h0000_1234);
        check("lh_a2_count", commit_count, 32'd3);

        drive(1'b1, 1'b1, 1'b1, 3'b100, 5'd6, 32'h0000_0000, 32'hABCD_8001);
        tick();
        check("lhu_a0_data", writeData, 32'h0000_8001);

        drive(1'b1, 1'b1, 1'b1, 3'b011, 5'd6, 32'h0000_0000, 32'hABCD_8001);
        tick();
        check("lh_a0_data", writeData, 32'hFFFF_8001);

        drive(1'b1, 1'b1, 1'b1, 3'b000, 5'd6, 32'h0000_0100, 32'hDEAD_BEEF);
        tick();
        check("lw_data", writeData, 32'hDEAD_BEEF);

        drive(1'b1, 1'b1, 1'b1, 3'b111, 5'd6, 32'h0000_0200, 32'h0102_0304);
        tick();
        check("lt111_data", writeData, 32'h0102_0304);
        check("lt111_rw",   {31'd0, regWrite}, 32'd1);

        drive(1'b1, 1'b1, 1'b1, 3'b001, 5'd6, 32'h0000_0003, 32'h7F00_0000);
        tick();
        check("lb_a3_data", writeData, 32'h0000_007F);
        check("lb_a3_count", commit_count, 32'd8);

        // r0 suppression
        drive(1'b1, 1'b1, 1'b0, 3'd0, 5'd0, 32'h0000_0055, 32'h0);
        tick();
        check("r0_regWrite",  {31'd0, regWrite}, 32'd0);
        check("r0_fwd_valid", {31'd0, fwd_valid}, 32'd0);
        check("r0_writeData", writeData, 32'h0000_0055);
        check("r0_count_a",   commit_count, 32'd9);
        drive(1'b0, 1'b1, 1'b0, 3'd0, 5'd0, 32'h0, 32'h0);
        tick();
        check("r0_count_b",   commit_count, 32'd9);

        // Stall three cycles on a write entry
        drive(1'b1, 1'b1, 1'b0, 3'd0, 5'd7, 32'hA5A5_A5A5, 32'h0);
        tick();
        check("st0_rw",  {31'd0, regWrite}, 32'd1);
        check("st0_fwd", {31'd0, fwd_valid}, 32'd1);
        stall = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 3'd0, 5'd9, 32'h0000_0001, 32'h0);
        tick();
        check("st1_rw",    {31'd0, regWrite}, 32'd0);
        check("st1_fwd",   {31'd0, fwd_valid}, 32'd1);
        check("st1_wreg",  {27'd0, writeReg}, 32'd7);
        check("st1_wdata", writeData, 32'hA5A5_A5A5);
        check("st1_count", commit_count, 32'd10);
        tick();
        check("st2_rw",  {31'd0, regWrite}, 32'd0);
        check("st2_fwd", {31'd0, fwd_valid}, 32'd1);
        tick();
        check("st3_rw",    {31'd0, regWrite}, 32'd0);
        check("st3_fwd",   {31'd0, fwd_valid}, 32'd1);
        check("st3_count", commit_count, 32'd10);
        stall = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 32'h0, 32'h0);
        tick();
        check("st_end_fwd",   {31'd0, fwd_valid}, 32'd0);
        check("st_end_count", commit_count, 32'd10);

        // Misaligned LH, then a good entry: misalign stays set
        drive(1'b1, 1'b1, 1'b1, 3'b011, 5'd8, 32'h0000_0003, 32'h1111_2222);
        tick();
        check("mis_rw",  {31'd0, regWrite}, 32'd0);
        check("mis_fwd", {31'd0, fwd_valid}, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 3'd0, 5'd9, 32'h0000_0011, 32'h0);
        tick();
        check("mis_flag_a",  {31'd0, misalign}, 32'd1);
        check("mis_good_rw", {31'd0, regWrite}, 32'd1);
        check("mis_count_a", commit_count, 32'd10);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 32'h0, 32'h0);
        tick();
        check("mis_flag_b",  {31'd0, misalign}, 32'd1);
        check("mis_count_b", commit_count, 32'd11);

        // Flush during a stalled, already-written entry
        drive(1'b1, 1'b1, 1'b0, 3'd0, 5'd10, 32'h0000_0022, 32'h0);
        tick();
        check("fl_rw0", {31'd0, regWrite}, 32'd1);
        stall = 1'b1;
        tick();
        check("fl_rw1",    {31'd0, regWrite}, 32'd0);
        check("fl_count1", commit_count, 32'd12);
        flush = 1'b1;
        tick();
        check("fl_rw2",    {31'd0, regWrite}, 32'd0);
        check("fl_fwd2",   {31'd0, fwd_valid}, 32'd0);
        check("fl_count2", commit_count, 32'd12);
        flush = 1'b0;
        stall = 1'b0;

        // Reset pulse mid-stall
        drive(1'b1, 1'b1, 1'b0, 3'd0, 5'd11, 32'h0000_0033, 32'h0);
        tick();
        check("rs_rw0", {31'd0, regWrite}, 32'd1);
        stall = 1'b1;
        tick();
        check("rs_count_pre", commit_count, 32'd13);
        #2 rst = 1'b1;
        #1;
        check("rs_rw",    {31'd0, regWrite}, 32'd0);
        check("rs_wreg",  {27'd0, writeReg}, 32'd0);
        check("rs_wdata", writeData, 32'd0);
        check("rs_fwd",   {31'd0, fwd_valid}, 32'd0);
        check("rs_freg",  {27'd0, fwd_reg}, 32'd0);
        check("rs_fdata", fwd_data, 32'd0);
        check("rs_mis",   {31'd0, misalign}, 32'd0);
        check("rs_count", commit_count, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("rs_held_rw",    {31'd0, regWrite}, 32'd0);
        check("rs_held_count", commit_count, 32'd0);
        stall = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 3'd0, 5'd12, 32'h0000_0044, 32'h0);
        tick();
        check("rs_new_rw",    {31'd0, regWrite}, 32'd1);
        check("rs_new_wdata", writeData, 32'h0000_0044);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 32'h0, 32'h0);
        tick();
        check("rs_new_count", commit_count, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
